// File: rtl/apb_ucpd_cc_attach.sv
// Type-C attach/detach detector fed by the debounced CC1/CC2 vstate codes.
// Tracks attach state, plug orientation and sticky per-line/attach change events.
module apb_ucpd_cc_attach #(
   parameter int MS_CNT_MAX = 999,
   parameter int TMR_W      = 8
) (
   input  logic             ic_clk,
   input  logic             ic_rst_n,
   input  logic [5:0]       clk_freq,
   input  logic [1:0]       cc_en,
   input  logic [1:0]       cc1_vstate,
   input  logic [1:0]       cc2_vstate,
   input  logic [TMR_W-1:0] t_ccdb_ms,
   input  logic [4:0]       t_pd_ms,
   input  logic [2:0]       evt_clr,
   input  logic [2:0]       evt_ie,
   output logic [2:0]       typec_evt,
   output logic             irq,
   output logic             attached,
   output logic             orient,
   output logic [1:0]       cc_state
);

   localparam int MS_W = (MS_CNT_MAX < 1) ? 1 : $clog2(MS_CNT_MAX + 1);
   localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_CNT_MAX);

   typedef enum logic [1:0] {
      ST_UNATTACHED  = 2'b00,
      ST_ATTACH_WAIT = 2'b01,
      ST_ATTACHED    = 2'b10,
      ST_DETACH_WAIT = 2'b11
   } cc_state_t;

   cc_state_t        state_q, state_d;
   logic             cand_q, cand_d;
   logic             orient_q;
   logic [5:0]       us_cnt;
   logic [MS_W-1:0]  ms_cnt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_eff;
   logic [1:0]       prev_v1, prev_v2;
   logic [1:0]       v1, v2, active_v;
   logic [5:0]       us_last;
   logic             connect, cand, us_wrap, ms_tick;
   logic             wait_entry, att_evt;
   logic             ccdb_hit, pd_hit;

   assign v1       = cc_en[0] ? cc1_vstate : 2'd0;
   assign v2       = cc_en[1] ? cc2_vstate : 2'd0;
   assign connect  = (v1 != 2'd0) ^ (v2 != 2'd0);
   assign cand     = (v2 != 2'd0);
   assign active_v = orient_q ? v2 : v1;

   assign us_last   = (clk_freq == 6'd0) ? 6'd0 : clk_freq - 6'd1;
   assign us_wrap   = (us_cnt >= us_last);
   assign ms_tick   = us_wrap && (ms_cnt >= MS_LAST);
   // Timer value including this cycle's ms tick, so a wait of N ms ends on the Nth tick edge
   assign timer_eff = (ms_tick && (timer != {TMR_W{1'b1}})) ? timer + TMR_W'(1) : timer;
   assign ccdb_hit  = (timer == t_ccdb_ms) || (timer_eff == t_ccdb_ms);
   assign pd_hit    = (timer == TMR_W'(t_pd_ms)) || (timer_eff == TMR_W'(t_pd_ms));

   always_comb begin
      state_d    = state_q;
      cand_d     = cand_q;
      wait_entry = 1'b0;
      att_evt    = 1'b0;
      case (state_q)
         ST_UNATTACHED: begin
            if (connect) begin
               state_d    = ST_ATTACH_WAIT;
               cand_d     = cand;
               wait_entry = 1'b1;
            end
         end
         ST_ATTACH_WAIT: begin
            if (!connect || (cand != cand_q)) begin
               state_d = ST_UNATTACHED;
            end else if (ccdb_hit) begin
               state_d = ST_ATTACHED;
               att_evt = 1'b1;
            end
         end
         ST_ATTACHED: begin
            if (active_v == 2'd0) begin
               state_d    = ST_DETACH_WAIT;
               wait_entry = 1'b1;
            end
         end
         ST_DETACH_WAIT: begin
            if (active_v != 2'd0) begin
               state_d = ST_ATTACHED;
            end else if (pd_hit) begin
               state_d = ST_UNATTACHED;
               att_evt = 1'b1;
            end
         end
         default: state_d = ST_UNATTACHED;
      endcase
   end

   always_ff @(posedge ic_clk or negedge ic_rst_n) begin
      if (!ic_rst_n) begin
         state_q   <= ST_UNATTACHED;
         cand_q    <= 1'b0;
         orient_q  <= 1'b0;
         us_cnt    <= '0;
         ms_cnt    <= '0;
         timer     <= '0;
         prev_v1   <= 2'd0;
         prev_v2   <= 2'd0;
         typec_evt <= 3'b000;
         irq       <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         if ((state_q == ST_ATTACH_WAIT) && (state_d == ST_ATTACHED)) begin
            orient_q <= cand_q;
         end
         if (wait_entry) begin
            us_cnt <= '0;
            ms_cnt <= '0;
            timer  <= '0;
         end else begin
            us_cnt <= us_wrap ? 6'd0 : us_cnt + 6'd1;
            if (us_wrap) begin
               ms_cnt <= (ms_cnt >= MS_LAST) ? '0 : ms_cnt + MS_W'(1);
            end
            timer <= timer_eff;
         end
         prev_v1 <= v1;
         prev_v2 <= v2;
         // New events are ORed in after the clear so a same-cycle set wins
         typec_evt <= (typec_evt & ~evt_clr) | {att_evt, (v2 != prev_v2), (v1 != prev_v1)};
         irq       <= |(typec_evt & evt_ie);
      end
   end

   assign attached = state_q[1];
   assign orient   = orient_q;
   assign cc_state = state_q;

endmodule

// File: tb/tb_apb_ucpd_cc_attach.sv
// Directed self-checking bench for apb_ucpd_cc_attach with hand-computed expectations.
module tb_apb_ucpd_cc_attach;

   logic       ic_clk = 1'b0;
   logic       ic_rst_n;
   logic [5:0] clk_freq;
   logic [1:0] cc_en;
   logic [1:0] cc1_vstate;
   logic [1:0] cc2_vstate;
   logic [7:0] t_ccdb_ms;
   logic [4:0] t_pd_ms;
   logic [2:0] evt_clr;
   logic [2:0] evt_ie;
   logic [2:0] typec_evt;
   logic       irq;
   logic       attached;
   logic       orient;
   logic [1:0] cc_state;

   int checkCount = 0;
   int failCount  = 0;

   always #5 ic_clk = ~ic_clk;

   apb_ucpd_cc_attach dut (
      .ic_clk     (ic_clk),
      .ic_rst_n   (ic_rst_n),
      .clk_freq   (clk_freq),
      .cc_en      (cc_en),
      .cc1_vstate (cc1_vstate),
      .cc2_vstate (cc2_vstate),
      .t_ccdb_ms  (t_ccdb_ms),
      .t_pd_ms    (t_pd_ms),
      .evt_clr    (evt_clr),
      .evt_ie     (evt_ie),
      .typec_evt  (typec_evt),
      .irq        (irq),
      .attached   (attached),
      .orient     (orient),
      .cc_state   (cc_state)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] cc1, input logic [1:0] cc2);
      cc1_vstate = cc1;
      cc2_vstate = cc2;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge ic_clk);
   endtask

   task automatic clearEvents();
      evt_clr = 3'b111;
      tick(1);
      evt_clr = 3'b000;
   endtask

   initial begin
      ic_rst_n   = 1'b0;
      clk_freq   = 6'd1;
      cc_en      = 2'b11;
      cc1_vstate = 2'd0;
      cc2_vstate = 2'd0;
      t_ccdb_ms  = 8'd2;
      t_pd_ms    = 5'd0;
      evt_clr    = 3'b000;
      evt_ie     = 3'b111;
      tick(3);
      checkOutput("rst_state", cc_state, 0);
      checkOutput("rst_attached", attached, 0);
      checkOutput("rst_orient", orient, 0);
      checkOutput("rst_evt", typec_evt, 0);
      checkOutput("rst_irq", irq, 0);
      ic_rst_n = 1'b1;
      tick(2);

      // Attach on CC1 with a 2 ms debounce at 1 MHz
      applyStimulus(2'd2, 2'd0);
      tick(1);
      checkOutput("t1_enter_aw", cc_state, 1);
      checkOutput("t1_evt0", typec_evt[0], 1);
      tick(1999);
      checkOutput("t1_aw_at_1999", cc_state, 1);
      checkOutput("t1_not_attached_yet", attached, 0);
      tick(1);
      checkOutput("t1_attached_state", cc_state, 2);
      checkOutput("t1_attached", attached, 1);
      checkOutput("t1_orient", orient, 0);
      checkOutput("t1_evt2", typec_evt[2], 1);
      clearEvents();
      checkOutput("t1_evt_cleared", typec_evt, 0);

      // Immediate detach with zero tPD
      applyStimulus(2'd0, 2'd0);
      tick(1);
      checkOutput("det_dw", cc_state, 3);
      tick(1);
      checkOutput("det_unattached", cc_state, 0);
      checkOutput("det_attached", attached, 0);
      clearEvents();

      // Abort ATTACH_WAIT after 1500 cycles
      applyStimulus(2'd2, 2'd0);
      tick(1);
      checkOutput("t2_aw", cc_state, 1);
      tick(1499);
      applyStimulus(2'd0, 2'd0);
      tick(1);
      checkOutput("t2_unattached", cc_state, 0);
      checkOutput("t2_no_evt2", typec_evt[2], 0);
      checkOutput("t2_evt0", typec_evt[0], 1);
      clearEvents();

      // Abort beats a zero-length timeout in the same cycle
      t_ccdb_ms = 8'd0;
      applyStimulus(2'd2, 2'd0);
      tick(1);
      checkOutput("pri_aw", cc_state, 1);
      applyStimulus(2'd0, 2'd0);
      tick(1);
      checkOutput("pri_unattached", cc_state, 0);
      checkOutput("pri_no_evt2", typec_evt[2], 0);
      clearEvents();

      // Zero attach debounce, CC2 orientation
      t_pd_ms = 5'd1;
      applyStimulus(2'd0, 2'd3);
      tick(1);
      checkOutput("t6_aw", cc_state, 1);
      tick(1);
      checkOutput("t6_attached", cc_state, 2);
      checkOutput("t6_orient", orient, 1);
      clearEvents();

      // Short dropout on CC2 recovers, long one detaches after 1 ms
      applyStimulus(2'd0, 2'd0);
      tick(1);
      checkOutput("t3_dw", cc_state, 3);
      checkOutput("t3_dw_attached", attached, 1);
      tick(499);
      applyStimulus(2'd0, 2'd3);
      tick(1);
      checkOutput("t3_recovered", cc_state, 2);
      checkOutput("t3_no_evt2", typec_evt[2], 0);
      applyStimulus(2'd0, 2'd0);
      tick(1);
      checkOutput("t3_dw2", cc_state, 3);
      tick(999);
      checkOutput("t3_dw_at_999", cc_state, 3);
      tick(1);
      checkOutput("t3_unattached", cc_state, 0);
      checkOutput("t3_attached_low", attached, 0);
      checkOutput("t3_evt2", typec_evt[2], 1);
      checkOutput("t3_orient_hold", orient, 1);

      // Both lines driven: no attach, per-line events, masked irq
      evt_ie = 3'b001;
      clearEvents();
      tick(1);
      checkOutput("t4_irq_idle", irq, 0);
      applyStimulus(2'd1, 2'd1);
      tick(1);
      checkOutput("t4_evt", typec_evt, 3'b011);
      checkOutput("t4_state", cc_state, 0);
      checkOutput("t4_irq_lag", irq, 0);
      tick(1);
      checkOutput("t4_irq", irq, 1);
      checkOutput("t4_state_hold", cc_state, 0);
      evt_ie = 3'b100;
      tick(1);
      checkOutput("t4_irq_masked", irq, 0);

      // Set wins over a same-cycle clear
      applyStimulus(2'd2, 2'd1);
      evt_clr = 3'b001;
      tick(1);
      evt_clr = 3'b000;
      checkOutput("t5_set_wins", typec_evt[0], 1);
      evt_clr = 3'b001;
      tick(1);
      evt_clr = 3'b000;
      checkOutput("t5_clr_alone", typec_evt[0], 0);
      clearEvents();

      // Disabling CC2 counts as a change and leaves a single connected line
      cc_en = 2'b01;
      tick(1);
      checkOutput("en_evt1", typec_evt[1], 1);
      checkOutput("en_evt0", typec_evt[0], 0);
      checkOutput("en_aw", cc_state, 1);
      tick(1);
      checkOutput("en_attached", cc_state, 2);
      checkOutput("en_orient", orient, 0);

      // Async reset in the middle of DETACH_WAIT
      t_pd_ms = 5'd5;
      applyStimulus(2'd0, 2'd1);
      tick(1);
      checkOutput("t6_dw", cc_state, 3);
      tick(1);
      checkOutput("pre_rst_evt2", typec_evt[2], 1);
      checkOutput("pre_rst_irq", irq, 1);
      #2 ic_rst_n = 1'b0;
      #1;
      checkOutput("arst_state", cc_state, 0);
      checkOutput("arst_attached", attached, 0);
      checkOutput("arst_orient", orient, 0);
      checkOutput("arst_evt", typec_evt, 0);
      checkOutput("arst_irq", irq, 0);
      tick(2);
      ic_rst_n = 1'b1;
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
